wb_burst_reader: RTL

Wishbone master that sits directly upstream of the Wishbone block RAM slave and the other memory slaves on the shared bus. On a start request it reads `nwords` consecutive 32-bit words from a base address as linear incrementing bursts (cti=010) and buffers the data in an internal FIFO. A valid/ready stream delivers the FIFO contents to a consumer, such as the display or copy logic. Bursts are throttled so the FIFO can never overflow.

---
 rtl/wb_burst_reader_if.sv | 22 ++
 rtl/wb_burst_reader.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/wb_burst_reader_if.sv
// Wishbone B4 master-side bundle for the burst reader.
// Clock and reset travel with the bus signals.
interface wb_burst_reader_if;
  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        ack;
  logic [2:0]  cti;
  logic [1:0]  bte;

  modport master (
    input  clk, rst, dat_sm, ack,
    output cyc, stb, we, sel, adr,
    output dat_ms, cti, bte
  );
endinterface

// File: rtl/wb_burst_reader.sv
// Wishbone burst read master feeding a show-ahead FIFO.
// Bursts start only when the FIFO can absorb every beat.
module wb_burst_reader #(
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned FIFO_DEPTH = 32
) (
  wb_burst_reader_if.master wb_m,
  input  logic        start,
  input  logic [31:0] base_adr,
  input  logic [15:0] nwords,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(BURST_LEN) + 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPACE,
    BURST,
    GAP,
    DONE
  } state_t;

  state_t         state;
  logic [31:0]    adr_q;
  logic [15:0]    remaining;
  logic [BW-1:0]  beats;
  logic           cyc_q;
  logic [2:0]     cti_q;

  logic [31:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  logic           push;
  logic           pop;
  logic [31:0]    blen;
  logic [31:0]    free_slots;

  assign push = cyc_q & wb_m.ack;
  assign pop  = rd_valid & rd_ready;

  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];

  assign blen = (32'(remaining) < BURST_LEN)
              ? 32'(remaining) : BURST_LEN;
  // a pop in this cycle frees a slot before the burst begins
  assign free_slots = FIFO_DEPTH - 32'(count)
                    + 32'(pop);

  assign wb_m.cyc    = cyc_q;
  assign wb_m.stb    = cyc_q;
  assign wb_m.we     = 1'b0;
  assign wb_m.sel    = 4'hF;
  assign wb_m.adr    = adr_q;
  assign wb_m.dat_ms = '0;
  assign wb_m.cti    = cti_q;
  assign wb_m.bte    = 2'b00;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge wb_m.clk) begin
    if (wb_m.rst) begin
      state     <= IDLE;
      adr_q     <= '0;
      remaining <= '0;
      beats     <= '0;
      cyc_q     <= 1'b0;
      cti_q     <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            adr_q     <= {base_adr[31:2], 2'b00};
            remaining <= nwords;
            state     <= (nwords == 16'd0)
                       ? DONE : WAIT_SPACE;
          end
        end
        WAIT_SPACE: begin
          if (free_slots >= blen) begin
            state <= BURST;
            cyc_q <= 1'b1;
            beats <= blen[BW-1:0];
            cti_q <= (blen == 32'd1)
                   ? 3'b000 : 3'b010;
          end
        end
        BURST: begin
          if (wb_m.ack) begin
            adr_q     <= adr_q + 32'd4;
            remaining <= remaining - 16'd1;
            beats     <= beats - BW'(1);
            if (beats == BW'(1)) begin
              state <= GAP;
              cyc_q <= 1'b0;
              cti_q <= 3'b000;
            end else if (beats == BW'(2)) begin
              cti_q <= 3'b111;
            end
          end
        end
        GAP: begin
          state <= (remaining == 16'd0)
                 ? DONE : WAIT_SPACE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge wb_m.clk) begin
    if (wb_m.rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge wb_m.clk) begin
    if (push) mem[wr_ptr] <= wb_m.dat_sm;
  end

  a_no_overflow: assert property (
    @(posedge wb_m.clk) disable iff (wb_m.rst)
    push |-> (count < CW'(FIFO_DEPTH))
  );
endmodule
